// File: rtl/identifier_fsm.sv
// Byte-serial identifier recogniser: raises out while the current alphanumeric
// token is letter-led and its most recent character is a digit.
module identifier_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char,
  output logic       out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALPHA = 2'd1;
  localparam logic [1:0] NUM   = 2'd2;
  localparam logic [1:0] BAD   = 2'd3;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       is_letter;
  logic       is_digit;

  // Full 8-bit range compares; bytes 0x80-0xFF fall through to separator.
  always_comb begin
    is_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                ((char >= 8'h61) && (char <= 8'h7A));
    is_digit  = (char >= 8'h30) && (char <= 8'h39);
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (is_letter)     state_d = ALPHA;
        else if (is_digit) state_d = BAD;
        else               state_d = IDLE;
      end
      ALPHA, NUM: begin
        if (is_letter)     state_d = ALPHA;
        else if (is_digit) state_d = NUM;
        else               state_d = IDLE;
      end
      BAD: begin
        if (is_letter || is_digit) state_d = BAD;
        else                       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Moore output: no path from char.
  assign out = (state_q == NUM);

endmodule

// File: tb/tb_identifier_fsm.sv
// Scoreboarded bench for identifier_fsm against a token-buffer reference model.
module tb_identifier_fsm;

  logic       clk;
  logic       rst_n;
  logic [7:0] char;
  logic       out;

  int unsigned vectors;
  int unsigned miscompares;

  logic        exp_q[$];
  byte unsigned tok[$];
  logic        last_exp;
  logic        have_last;

  identifier_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .char  (char),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit letter(input byte unsigned c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic bit digit(input byte unsigned c);
    return c >= "0" && c <= "9";
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: out=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: keep the current token verbatim and judge it by its first/last char.
  task automatic model_step(input byte unsigned c);
    logic e;
    if (letter(c) || digit(c)) tok.push_back(c);
    else tok.delete();
    e = (tok.size() > 0) && letter(tok[0]) && digit(tok[tok.size()-1]);
    exp_q.push_back(e);
  endtask

  task automatic apply(input byte unsigned c);
    @(negedge clk);
    char = c;
    @(posedge clk);
    model_step(c);
  endtask

  task automatic apply_str(input string s);
    for (int i = 0; i < s.len(); i++) apply(s[i]);
  endtask

  // Monitor: compare just after each rising edge, then confirm out holds mid-cycle.
  initial begin
    logic e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("post_edge", out, e);
        last_exp  = e;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (have_last && rst_n) check("mid_cycle_hold", out, last_exp);
    end
  end

  initial begin
    byte unsigned c;
    int unsigned r;
    vectors     = 0;
    miscompares = 0;
    have_last   = 1'b0;
    last_exp    = 1'b0;
    rst_n       = 1'b0;
    char        = 8'h00;

    repeat (2) @(posedge clk);
    #2;
    check("reset_state", out, 1'b0);
    rst_n = 1'b1;

    repeat (4) apply(8'h00);
    apply_str("Aa09$u5");
    apply(8'h20);
    apply_str("9a1 b2");
    apply(8'h20);

    // Class boundaries, each entered from a letter-led token.
    apply_str("a/a:a@a[a`a{");
    apply("a"); apply(8'hC1);
    apply(8'h80); apply("a"); apply(8'hFF);
    apply_str("aZz0");
    apply(8'h00);
    apply_str("x1");

    // Asynchronous reset between edges, mid-token.
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    have_last = 1'b0;
    tok.delete();
    #1;
    check("async_reset", out, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply_str("2;k7");

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      c = (r[0]) ? byte'($urandom_range(65, 90)) : byte'($urandom_range(97, 122));
      else if (r < 8) c = byte'($urandom_range(48, 57));
      else            c = byte'($urandom_range(0, 255));
      apply(c);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/identifier_fsm.md
Name: identifier_fsm

Overview:
Character-stream recogniser that scans one 8-bit ASCII character per clock and flags when the token received so far is a valid identifier ending in a digit.
- Token = maximal run of alphanumeric characters; any non-alphanumeric character is a separator.
- Valid identifier = starts with a letter, continues with letters/digits.
- out is asserted while the current token is a valid identifier whose most recent character is a digit.
- Sits behind a byte-serial character source, e.g. a lexer front-end.

Parameters:
none

Ports:
clk    input  1  rising-edge clock; char sampled on every rising edge
rst_n  input  1  asynchronous active-low reset
char   input  8  ASCII character presented this cycle
out    output 1  1 = current token is letter-led identifier ending in a digit

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low immediately forces state IDLE and out=0, regardless of clk. Release is sampled on the next rising edge.
- Character classes (full 8-bit compare, no masking):
  - LETTER: 0x41–0x5A ('A'–'Z') or 0x61–0x7A ('a'–'z').
  - DIGIT: 0x30–0x39 ('0'–'9').
  - OTHER: every other value, including 0x00, 0x2F '/', 0x3A ':', 0x40 '@', 0x5B '[', 0x60 '`', 0x7B '{', and all of 0x80–0xFF.
- States (Moore machine, one register update per rising edge):
  - IDLE: no token in progress.
  - ALPHA: valid identifier, last char a letter.
  - NUM: valid identifier, last char a digit.
  - BAD: token began with a digit; invalid until the next separator.
- Transitions (current state: LETTER / DIGIT / OTHER):
  - IDLE: ALPHA / BAD / IDLE
  - ALPHA: ALPHA / NUM / IDLE
  - NUM: ALPHA / NUM / IDLE
  - BAD: BAD / BAD / IDLE
- out = 1 iff state == NUM. It is decoded from the state register only, with no combinational path from char.
- Latency: char sampled at edge k is reflected on out immediately after edge k, and holds until edge k+1.
- No handshake. Every rising edge with rst_n high consumes char, including 0x00, which is a separator.
- A letter after digits in a valid token returns to ALPHA (out drops); e.g. "a1b" -> out 0 after 'b'.
- Reset mid-token discards the token. The first char after release is treated as the start of a new token.
- State encoding is free; unused encodings must recover to IDLE on the next edge.

Test Plan:
- rst_n=0 with char=0x00, then release -> out=0 (IDLE). Feeding 0x00 for several cycles keeps out=0.
- After reset, feed 'A','a','0','9','$','u','5', one per edge:
  - out after each edge = 0,0,1,1,0,0,1.
  - Check out changes only just after rising edges.
- Feed '9','a','1', then ' ', then 'b','2':
  - out = 0,0,0 (BAD persists across alnum).
  - then 0 on ' '.
  - then 0,1.
- Class boundaries, each fed from ALPHA state:
  - '/' and ':' -> IDLE, out=0.
  - '@', '[', '`', '{' -> IDLE.
  - 0xC1 -> IDLE.
  - 'Z','z' -> stay ALPHA.
  - '0' -> NUM, out=1.
- Feed 'x','1' (out=1), then pull rst_n low between edges:
  - out falls to 0 asynchronously, before the next edge.
  - After release, feed '2' -> out stays 0 (BAD).
  - Then ';','k','7' -> out=0,0,1.
